sprite_mixer_collision: RTL and testbench

- Downstream of the per-sprite renderers (player sprite and obstacle sprites); consumes each renderer's red/green/blue/imagen output.
- Each pixel clock: merges the layers by fixed priority over a background colour and registers the final VGA colour.
- Also counts player/obstacle overlap pixels per frame and runs the hit / invulnerability / game-over FSM that the game logic reads.

---
 rtl/sprite_mixer_collision.sv | 110 +++++++++++
 tb/tb_sprite_mixer_collision.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mixer_collision.sv
// Priority sprite mixer (player > obstacle 0..N-1 > background) plus per-frame overlap hit FSM.
// Colour and status outputs are registered (1-cycle latency); one pixel per clock, no backpressure.
module sprite_mixer_collision #(
    parameter int NUM_OBS         = 4,
    parameter int FRAME_END_LINE  = 480,
    parameter int HIT_THRESH      = 4,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int MAX_HITS        = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [9:0]             hcount,
    input  logic [9:0]             vcount,
    input  logic                   video_on,
    input  logic [2:0]             player_red,
    input  logic [2:0]             player_green,
    input  logic [1:0]             player_blue,
    input  logic                   player_imagen,
    input  logic [8*NUM_OBS-1:0]   obs_rgb,
    input  logic [NUM_OBS-1:0]     obs_imagen,
    input  logic [7:0]             bg_rgb,
    output logic [2:0]             red,
    output logic [2:0]             green,
    output logic [1:0]             blue,
    output logic                   collision,
    output logic                   invulnerable,
    output logic                   game_over,
    output logic [3:0]             hits
);
    typedef enum logic [1:0] {ARMED = 2'd0, COOLDOWN = 2'd1, OVER = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [15:0] overlap_cnt;
    logic [7:0]  cooldown_cnt, cooldown_nxt;
    logic [3:0]  hits_nxt, hits_inc;
    logic        collision_nxt;
    logic        frame_tick, pix_on, overlap_pix;
    logic [7:0]  mix_rgb;

    assign frame_tick  = (hcount == 10'd0) && (vcount == 10'(FRAME_END_LINE));
    assign pix_on      = enable && video_on;
    assign overlap_pix = pix_on && player_imagen && (|obs_imagen);
    assign hits_inc    = hits + 4'd1;

    // Walk obstacles high-to-low so the lowest opaque index is the one left standing.
    always_comb begin
        mix_rgb = bg_rgb;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (obs_imagen[i]) mix_rgb = obs_rgb[8*i +: 8];
        end
        if (player_imagen) mix_rgb = {player_red, player_green, player_blue};
        if (!pix_on)       mix_rgb = 8'h00;
    end

    always_comb begin
        state_nxt     = state;
        hits_nxt      = hits;
        cooldown_nxt  = cooldown_cnt;
        collision_nxt = 1'b0;
        if (enable && frame_tick) begin
            case (state)
                ARMED: begin
                    if (overlap_cnt >= 16'(HIT_THRESH)) begin
                        collision_nxt = 1'b1;
                        hits_nxt      = hits_inc;
                        if (hits_inc == 4'(MAX_HITS)) begin
                            state_nxt = OVER;
                        end else begin
                            state_nxt    = COOLDOWN;
                            cooldown_nxt = 8'(COOLDOWN_FRAMES);
                        end
                    end
                end
                COOLDOWN: begin
                    cooldown_nxt = cooldown_cnt - 8'd1;
                    if (cooldown_cnt == 8'd1) state_nxt = ARMED;
                end
                OVER:    state_nxt = OVER;
                default: state_nxt = ARMED;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            {red, green, blue} <= 8'h00;
            collision          <= 1'b0;
            invulnerable       <= 1'b0;
            game_over          <= 1'b0;
            hits               <= 4'd0;
            state              <= ARMED;
            cooldown_cnt       <= 8'd0;
            overlap_cnt        <= 16'd0;
        end else begin
            {red, green, blue} <= mix_rgb;
            collision          <= collision_nxt;
            invulnerable       <= (state_nxt == COOLDOWN);
            game_over          <= (state_nxt == OVER);
            hits               <= hits_nxt;
            state              <= state_nxt;
            cooldown_cnt       <= cooldown_nxt;
            // The tick clear wins over a coincident overlap pixel.
            if (frame_tick)
                overlap_cnt <= 16'd0;
            else if (overlap_pix && (overlap_cnt != 16'hFFFF))
                overlap_cnt <= overlap_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_sprite_mixer_collision.sv
// Randomized and directed bench for sprite_mixer_collision against a frame-level behavioural model.
module tb_sprite_mixer_collision;
    localparam int NUM_OBS         = 4;
    localparam int FRAME_END_LINE  = 480;
    localparam int HIT_THRESH      = 4;
    localparam int COOLDOWN_FRAMES = 2;
    localparam int MAX_HITS        = 3;

    logic                 clock = 1'b0;
    logic                 reset, enable, video_on, player_imagen;
    logic [9:0]           hcount, vcount;
    logic [2:0]           player_red, player_green;
    logic [1:0]           player_blue;
    logic [8*NUM_OBS-1:0] obs_rgb;
    logic [NUM_OBS-1:0]   obs_imagen;
    logic [7:0]           bg_rgb;
    logic [2:0]           red, green;
    logic [1:0]           blue;
    logic                 collision, invulnerable, game_over;
    logic [3:0]           hits;

    sprite_mixer_collision #(
        .NUM_OBS(NUM_OBS), .FRAME_END_LINE(FRAME_END_LINE), .HIT_THRESH(HIT_THRESH),
        .COOLDOWN_FRAMES(COOLDOWN_FRAMES), .MAX_HITS(MAX_HITS)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .hcount(hcount), .vcount(vcount),
        .video_on(video_on), .player_red(player_red), .player_green(player_green),
        .player_blue(player_blue), .player_imagen(player_imagen), .obs_rgb(obs_rgb),
        .obs_imagen(obs_imagen), .bg_rgb(bg_rgb), .red(red), .green(green), .blue(blue),
        .collision(collision), .invulnerable(invulnerable), .game_over(game_over), .hits(hits)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad = 0;
    bit   checking = 1'b0;

    // Behavioural model: overlap pixels this frame, frames of cooldown left, hits, game over.
    int         m_ovl = 0;
    int         m_cool = 0;
    int         m_hits = 0;
    bit         m_over = 1'b0;
    bit         e_coll = 1'b0;
    bit         e_inv = 1'b0;
    logic [7:0] e_rgb = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step();
        bit         tk, opix;
        logic [7:0] c;
        tk   = (hcount == 10'd0) && (vcount == 10'(FRAME_END_LINE));
        opix = enable && video_on && player_imagen && (obs_imagen != '0);
        c    = bg_rgb;
        for (int i = NUM_OBS - 1; i >= 0; i--)
            if (obs_imagen[i]) c = obs_rgb[8*i +: 8];
        if (player_imagen) c = {player_red, player_green, player_blue};
        if (!(enable && video_on)) c = 8'h00;
        e_coll = 1'b0;
        if (reset) begin
            checking = 1'b1;
            e_rgb = 8'h00; m_ovl = 0; m_cool = 0; m_hits = 0; m_over = 1'b0;
        end else begin
            e_rgb = c;
            if (enable && tk && !m_over) begin
                if (m_cool > 0) begin
                    m_cool = m_cool - 1;
                end else if (m_ovl >= HIT_THRESH) begin
                    e_coll = 1'b1;
                    m_hits = m_hits + 1;
                    if (m_hits == MAX_HITS) m_over = 1'b1;
                    else                    m_cool = COOLDOWN_FRAMES;
                end
            end
            if (tk)                        m_ovl = 0;
            else if (opix && m_ovl < 65535) m_ovl = m_ovl + 1;
        end
        e_inv = (m_cool > 0) && !m_over;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
        #1;
        if (checking)
            chk("outputs_vs_model", {17'd0, red, green, blue, collision, invulnerable, game_over, hits},
                {17'd0, e_rgb, e_coll, e_inv, m_over, 4'(m_hits)});
    end

    task automatic drive(input bit v, input bit p, input logic [3:0] o, input bit tk);
        @(negedge clock);
        video_on = v; player_imagen = p; obs_imagen = o;
        hcount = tk ? 10'd0 : 10'd5;
        vcount = tk ? 10'(FRAME_END_LINE) : 10'd100;
        @(posedge clock);
        #2;
    endtask

    task automatic overlaps(input int n);
        repeat (n) drive(1'b1, 1'b1, 4'b0001, 1'b0);
    endtask

    task automatic tick();
        drive(1'b0, 1'b0, 4'b0000, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    task automatic chk_status(input string name, input bit c, input bit inv, input bit ov, input int h);
        chk(name, {28'd0, collision, invulnerable, game_over, 1'b0}, {28'd0, c, inv, ov, 1'b0});
        chk({name, "_hits"}, {28'd0, hits}, 32'(h));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; video_on = 1'b0; player_imagen = 1'b0;
        hcount = 10'd5; vcount = 10'd100;
        player_red = 3'd7; player_green = 3'd0; player_blue = 2'd0;
        obs_rgb = {8'h00, 8'h03, 8'h1C, 8'h00}; obs_imagen = '0; bg_rgb = 8'h92;

        do_reset();
        chk("reset_rgb", {24'd0, red, green, blue}, 32'h00);
        chk_status("reset_status", 1'b0, 1'b0, 1'b0, 0);

        // Priority: player over obstacles over background, blanking forces black.
        drive(1'b1, 1'b1, 4'b0110, 1'b0);
        chk("prio_player", {24'd0, red, green, blue}, 32'hE0);
        drive(1'b1, 1'b0, 4'b0110, 1'b0);
        chk("prio_obs1", {24'd0, red, green, blue}, 32'h1C);
        drive(1'b1, 1'b0, 4'b0000, 1'b0);
        chk("prio_bg", {24'd0, red, green, blue}, 32'h92);
        drive(1'b0, 1'b0, 4'b0110, 1'b0);
        chk("prio_blank", {24'd0, red, green, blue}, 32'h00);
        tick();
        chk_status("prio_tick", 1'b0, 1'b0, 1'b0, 0);

        // Threshold: 3 overlaps miss, 4 overlaps hit.
        overlaps(3); tick();
        chk_status("thresh_3", 1'b0, 1'b0, 1'b0, 0);
        overlaps(4); tick();
        chk_status("thresh_4", 1'b1, 1'b1, 1'b0, 1);
        chk("model_hits_1", 32'(m_hits), 32'd1);
        drive(1'b0, 1'b0, 4'b0000, 1'b0);
        chk_status("pulse_one_cycle", 1'b0, 1'b1, 1'b0, 1);

        // Cooldown: two frames of overlap ignored, then armed again.
        overlaps(10); tick();
        chk_status("cool_f1", 1'b0, 1'b1, 1'b0, 1);
        overlaps(10); tick();
        chk_status("cool_f2", 1'b0, 1'b0, 1'b0, 1);
        overlaps(4); tick();
        chk_status("rearm_hit", 1'b1, 1'b1, 1'b0, 2);

        // Reset mid-cooldown.
        overlaps(2);
        do_reset();
        chk("midreset_rgb", {24'd0, red, green, blue}, 32'h00);
        chk_status("midreset_status", 1'b0, 1'b0, 1'b0, 0);
        chk("midreset_ovl", 32'(dut.overlap_cnt), 32'd0);

        // Disabled frame: black output, no hit, counter still cleared by the tick.
        enable = 1'b0;
        overlaps(20);
        chk("dis_black", {24'd0, red, green, blue}, 32'h00);
        tick();
        chk_status("dis_tick", 1'b0, 1'b0, 1'b0, 0);
        chk("dis_ovl", 32'(dut.overlap_cnt), 32'd0);
        enable = 1'b1;

        // Game over on the third hit, then frozen.
        overlaps(4); tick(); tick(); tick();
        overlaps(4); tick(); tick(); tick();
        chk_status("pre_over", 1'b0, 1'b0, 1'b0, 2);
        overlaps(4); tick();
        chk_status("game_over", 1'b1, 1'b0, 1'b1, 3);
        overlaps(10); tick();
        chk_status("over_frozen", 1'b0, 1'b0, 1'b1, 3);
        chk("model_over", {31'd0, m_over}, 32'd1);

        // Saturation of the overlap counter.
        do_reset();
        overlaps(70000);
        chk("sat_cnt", 32'(dut.overlap_cnt), 32'd65535);
        chk("model_sat", 32'(m_ovl), 32'd65535);
        tick();
        chk_status("sat_hit", 1'b1, 1'b1, 1'b0, 1);
        chk("sat_clear", 32'(dut.overlap_cnt), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        repeat (3000) begin
            @(negedge clock);
            reset         = ($urandom_range(0, 299) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            video_on      = ($urandom_range(0, 3) != 0);
            player_imagen = $urandom_range(0, 1) == 1;
            obs_imagen    = 4'($urandom_range(0, 15));
            player_red    = 3'($urandom); player_green = 3'($urandom); player_blue = 2'($urandom);
            obs_rgb       = $urandom();
            bg_rgb        = 8'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                hcount = 10'd0; vcount = 10'(FRAME_END_LINE);
            end else begin
                hcount = 10'($urandom_range(1, 799)); vcount = 10'($urandom_range(0, 524));
            end
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
